scmp_bus_unit: RTL and testbench

// - Parametrised external bus sequencer for the SC/MP core family; successor to the fixed 12-bit, zero-wait bus strobes driven directly by microcode.
// - Core issues one read/write request; block runs ADS -> RD/WR (wait states + HOLD) -> tail, returns data; optional multi-master daisy-chain arbitration.
// - Sits between core datapath (addr/D regs, status flags) and the pins.

---
 rtl/scmp_bus_unit_pkg.sv | 22 ++
 rtl/scmp_bus_unit_if.sv | 29 ++
 rtl/scmp_bus_unit_arb.sv | 34 +++
 rtl/scmp_bus_unit.sv | 210 +++++++++++++++++++++
 tb/tb_scmp_bus_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/scmp_bus_unit_pkg.sv
// Shared types for the SC/MP external bus sequencer: FSM state encoding,
// cycle-type flags and the wait-counter width.
package scmp_bus_pak;

    localparam int WAIT_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        ADS  = 3'd2,
        XFER = 3'd3,
        TAIL = 3'd4
    } BUS_STATE_t;

    typedef struct packed {
        logic h;
        logic d;
        logic i;
        logic r;
    } BUS_FLAGS_t;

endpackage

// File: rtl/scmp_bus_unit_if.sv
// Core-side request/response channel of the bus sequencer.
// master = core datapath, slave = scmp_bus_unit.
interface scmp_bus_unit_if #(
    parameter int ADDR_W = 12,
    parameter int PAGE_W = 4,
    parameter int DATA_W = 8
);
    import scmp_bus_pak::*;

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDR_W+PAGE_W-1:0] req_addr;
    logic [DATA_W-1:0]        req_wdata;
    BUS_FLAGS_t               req_flags;
    logic                     rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_flags,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_flags,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/scmp_bus_unit_arb.sv
// Daisy-chain arbitration for the bus sequencer: bus request, grant
// qualification and downstream grant pass-through.
module scmp_bus_arb
    import scmp_bus_pak::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  BUS_STATE_t state_r,
    input  BUS_STATE_t state_nxt,
    input  logic       req_valid,
    input  logic       enin,
    input  logic       bus_busy,
    output logic       breq,
    output logic       enout,
    output logic       grant
);

    logic breq_r;

    assign grant = enin & ~bus_busy;
    // Priority is only handed on while this master is idle and not about to request.
    assign enout = enin & (state_r == IDLE) & ~req_valid;
    assign breq  = breq_r;

    // Bus request asserted from arbitration through the tail cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            breq_r <= 1'b0;
        end else begin
            breq_r <= (state_nxt != IDLE);
        end
    end

endmodule

// File: rtl/scmp_bus_unit.sv
// SC/MP external bus sequencer: ADS -> RD/WR (wait states + hold) -> tail.
// Define SCMP_BUS_ARB_EN to enable daisy-chain multi-master arbitration.
module scmp_bus_unit
    import scmp_bus_pak::*;
#(
    parameter int ADDR_W      = 12,
    parameter int PAGE_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    scmp_bus_unit_if.slave    bus,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [DATA_W-1:0] D_i,
    output logic [DATA_W-1:0] D_o,
    output logic              D_oe,
    output logic              ADS_n,
    output logic              RD_n,
    output logic              WR_n,
    input  logic              hold,
    input  logic              enin,
    input  logic              bus_busy,
    output logic              breq,
    output logic              enout
);

    localparam int AW = ADDR_W + PAGE_W;

    BUS_STATE_t          state_r, state_nxt;
    logic [WAIT_W-1:0]   cnt_r;
    logic                write_lat_r;
    logic [AW-1:0]       addr_lat_r;
    logic [DATA_W-1:0]   wdata_lat_r;
    BUS_FLAGS_t          flags_lat_r;
    logic                grant_s;

    logic                src_write_s;
    logic [AW-1:0]       src_addr_s;
    logic [DATA_W-1:0]   src_wdata_s;
    BUS_FLAGS_t          src_flags_s;

    logic [ADDR_W-1:0]   addr_nxt_s;
    logic [DATA_W-1:0]   d_o_nxt_s;
    logic                d_oe_nxt_s, ads_n_nxt_s, rd_n_nxt_s, wr_n_nxt_s;

    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   d_o_r, rdata_r;
    logic                d_oe_r, ads_n_r, rd_n_r, wr_n_r, rsp_valid_r, ready_r;

    // Address-phase word: flags in the top nibble, page in the low bits.
    function automatic logic [DATA_W-1:0] ads_word(input BUS_FLAGS_t f,
                                                   input logic [PAGE_W-1:0] pg);
        logic [DATA_W-1:0] w;
        w                 = '0;
        w[DATA_W-1 -: 4]  = f;
        w[PAGE_W-1:0]     = pg;
        return w;
    endfunction

`ifdef SCMP_BUS_ARB_EN
    localparam BUS_STATE_t ACCEPT_ST = ARB;

    scmp_bus_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .state_r   (state_r),
        .state_nxt (state_nxt),
        .req_valid (bus.req_valid),
        .enin      (enin),
        .bus_busy  (bus_busy),
        .breq      (breq),
        .enout     (enout),
        .grant     (grant_s)
    );
`else
    localparam BUS_STATE_t ACCEPT_ST = ADS;
    logic unused_busy_s;

    assign unused_busy_s = bus_busy;
    assign grant_s       = 1'b1;
    assign breq          = 1'b0;
    assign enout         = enin;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: if (bus.req_valid) state_nxt = ACCEPT_ST; else state_nxt = IDLE;
            ARB:  if (grant_s)       state_nxt = ADS;       else state_nxt = ARB;
            ADS:  state_nxt = XFER;
            XFER: if ((cnt_r == {WAIT_W{1'b0}}) && !hold) state_nxt = TAIL;
                  else state_nxt = XFER;
            TAIL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // While accepting, the pins are loaded straight from the request.
    always_comb begin
        if (state_r == IDLE) begin
            src_write_s = bus.req_write;
            src_addr_s  = bus.req_addr;
            src_wdata_s = bus.req_wdata;
            src_flags_s = bus.req_flags;
        end else begin
            src_write_s = write_lat_r;
            src_addr_s  = addr_lat_r;
            src_wdata_s = wdata_lat_r;
            src_flags_s = flags_lat_r;
        end
    end

    // Pin values for the state being entered.
    always_comb begin
        addr_nxt_s  = addr_r;
        d_o_nxt_s   = d_o_r;
        d_oe_nxt_s  = 1'b0;
        ads_n_nxt_s = 1'b1;
        rd_n_nxt_s  = 1'b1;
        wr_n_nxt_s  = 1'b1;
        case (state_nxt)
            ADS: begin
                ads_n_nxt_s = 1'b0;
                addr_nxt_s  = src_addr_s[ADDR_W-1:0];
                d_o_nxt_s   = ads_word(src_flags_s, src_addr_s[AW-1 -: PAGE_W]);
                d_oe_nxt_s  = 1'b1;
            end
            XFER: begin
                if (src_write_s) begin
                    wr_n_nxt_s = 1'b0;
                    d_o_nxt_s  = src_wdata_s;
                    d_oe_nxt_s = 1'b1;
                end else begin
                    rd_n_nxt_s = 1'b0;
                end
            end
            TAIL: begin
                if (src_write_s) begin
                    d_o_nxt_s  = src_wdata_s;
                    d_oe_nxt_s = 1'b1;
                end else begin
                    d_oe_nxt_s = 1'b0;
                end
            end
            default: begin
                d_oe_nxt_s = 1'b0;
            end
        endcase
    end

    // State, request latches, wait counter and registered pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {WAIT_W{1'b0}};
            write_lat_r <= 1'b0;
            addr_lat_r  <= '0;
            wdata_lat_r <= '0;
            flags_lat_r <= '0;
            addr_r      <= '0;
            d_o_r       <= '0;
            d_oe_r      <= 1'b0;
            ads_n_r     <= 1'b1;
            rd_n_r      <= 1'b1;
            wr_n_r      <= 1'b1;
            rsp_valid_r <= 1'b0;
            ready_r     <= 1'b1;
            rdata_r     <= '0;
        end else begin
            state_r     <= state_nxt;
            write_lat_r <= src_write_s;
            addr_lat_r  <= src_addr_s;
            wdata_lat_r <= src_wdata_s;
            flags_lat_r <= src_flags_s;
            if (state_r == ADS) begin
                cnt_r <= WAIT_W'(WAIT_STATES);
            end else if ((state_r == XFER) && (cnt_r != {WAIT_W{1'b0}})) begin
                cnt_r <= cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == XFER) && (state_nxt == TAIL) && !write_lat_r) begin
                rdata_r <= D_i;
            end else begin
                rdata_r <= rdata_r;
            end
            addr_r      <= addr_nxt_s;
            d_o_r       <= d_o_nxt_s;
            d_oe_r      <= d_oe_nxt_s;
            ads_n_r     <= ads_n_nxt_s;
            rd_n_r      <= rd_n_nxt_s;
            wr_n_r      <= wr_n_nxt_s;
            rsp_valid_r <= (state_nxt == TAIL);
            ready_r     <= (state_nxt == IDLE);
        end
    end

    assign addr_o        = addr_r;
    assign D_o           = d_o_r;
    assign D_oe          = d_oe_r;
    assign ADS_n         = ads_n_r;
    assign RD_n          = rd_n_r;
    assign WR_n          = wr_n_r;
    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rdata_r;

endmodule

// File: tb/tb_scmp_bus_unit.sv
// Directed bench for scmp_bus_unit: a zero-wait instance and a two-wait instance.
module tb_scmp_bus_unit;
    import scmp_bus_pak::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    logic [11:0] addr_o0, addr_o2;
    logic [7:0]  D_i0, D_i2, D_o0, D_o2;
    logic        D_oe0, D_oe2, ADS_n0, ADS_n2, RD_n0, RD_n2, WR_n0, WR_n2;
    logic        hold0, hold2, enin0, enin2, busy0, busy2, breq0, breq2, enout0, enout2;

    scmp_bus_unit_if if0 ();
    scmp_bus_unit_if if2 ();

    scmp_bus_unit #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .addr_o(addr_o0), .D_i(D_i0), .D_o(D_o0),
        .D_oe(D_oe0), .ADS_n(ADS_n0), .RD_n(RD_n0), .WR_n(WR_n0), .hold(hold0),
        .enin(enin0), .bus_busy(busy0), .breq(breq0), .enout(enout0)
    );

    scmp_bus_unit #(.WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .addr_o(addr_o2), .D_i(D_i2), .D_o(D_o2),
        .D_oe(D_oe2), .ADS_n(ADS_n2), .RD_n(RD_n2), .WR_n(WR_n2), .hold(hold2),
        .enin(enin2), .bus_busy(busy2), .breq(breq2), .enout(enout2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write on the two-wait instance; hold is high for XFER cycles [h_lo, h_hi).
    task automatic run_write2(input string tag, input int h_lo, input int h_hi, input int exp_wr);
        int wr_cnt;
        int pulses;
        wr_cnt = 0;
        pulses = 0;
        if2.req_valid = 1'b1;
        if2.req_write = 1'b1;
        if2.req_addr  = 16'h0123;
        if2.req_wdata = 8'hE1;
        if2.req_flags = 4'h4;
        step();
        if2.req_valid = 1'b0;
        check_eq({tag, "_ads_n"}, {31'd0, ADS_n2}, 32'd0);
        check_eq({tag, "_ads_d"}, {24'd0, D_o2}, 32'h40);
        check_eq({tag, "_ads_addr"}, {20'd0, addr_o2}, 32'h123);
        for (int i = 0; i < 12; i++) begin
            step();
            hold2 = (i >= h_lo) && (i < h_hi);
            if (!WR_n2) wr_cnt++;
            if (if2.rsp_valid) begin
                pulses++;
                check_eq({tag, "_tail_d"}, {24'd0, D_o2}, 32'hE1);
                check_eq({tag, "_tail_oe"}, {31'd0, D_oe2}, 32'd1);
            end
        end
        hold2 = 1'b0;
        check_eq({tag, "_wr_cycles"}, wr_cnt, exp_wr);
        check_eq({tag, "_rsp_pulses"}, pulses, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc[$];
        rst_n = 1'b0;
        {D_i0, D_i2} = 16'd0;
        {hold0, hold2, busy0, busy2} = 4'd0;
        enin0 = 1'b1;
        enin2 = 1'b1;
        if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = 16'd0;
        if0.req_wdata = 8'd0; if0.req_flags = 4'd0;
        if2.req_valid = 1'b0; if2.req_write = 1'b0; if2.req_addr = 16'd0;
        if2.req_wdata = 8'd0; if2.req_flags = 4'd0;
        step();
        step();

        // Reset values
        check_eq("rst_strobes", {29'd0, ADS_n0, RD_n0, WR_n0}, 32'd7);
        check_eq("rst_oe_d", {23'd0, D_oe0, D_o0}, 32'd0);
        check_eq("rst_addr", {20'd0, addr_o0}, 32'd0);
        check_eq("rst_rsp", {23'd0, if0.rsp_valid, if0.rsp_rdata}, 32'd0);
        check_eq("rst_ready_breq", {30'd0, if0.req_ready, breq0}, 32'd2);
        check_eq("rst_enout", {31'd0, enout0}, 32'd1);
        rst_n = 1'b1;
        step();

        // Zero-wait read
        if0.req_valid = 1'b1;
        if0.req_write = 1'b0;
        if0.req_addr  = 16'h3A5F;
        if0.req_flags = 4'h8;
        D_i0 = 8'h5C;
        check_eq("rd_t0_ready", {31'd0, if0.req_ready}, 32'd1);
        step();
        if0.req_valid = 1'b0;
        check_eq("rd_t1_ads", {29'd0, ADS_n0, RD_n0, D_oe0}, 32'h3);
        check_eq("rd_t1_addr", {20'd0, addr_o0}, 32'hA5F);
        check_eq("rd_t1_d", {24'd0, D_o0}, 32'h83);
        step();
        check_eq("rd_t2_strobes", {28'd0, ADS_n0, RD_n0, D_oe0, if0.req_ready}, 32'h8);
        step();
        check_eq("rd_t3_rsp", {30'd0, if0.rsp_valid, RD_n0}, 32'd3);
        check_eq("rd_t3_data", {24'd0, if0.rsp_rdata}, 32'h5C);
        D_i0 = 8'h00;
        step();
        check_eq("rd_t4_idle", {30'd0, if0.rsp_valid, if0.req_ready}, 32'd1);
        check_eq("rd_t4_hold_data", {24'd0, if0.rsp_rdata}, 32'h5C);
        check_eq("rd_t4_addr_kept", {20'd0, addr_o0}, 32'hA5F);

        // Two wait states: hold during counted waits does not stretch, hold at zero does
        run_write2("wr_hold_early", 0, 2, 3);
        run_write2("wr_hold_ext", 2, 4, 5);

        // Reset during the read strobe
        if0.req_valid = 1'b1;
        if0.req_addr  = 16'h0010;
        step();
        if0.req_valid = 1'b0;
        step();
        check_eq("rstx_rd_low", {31'd0, RD_n0}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("rstx_strobes", {29'd0, ADS_n0, RD_n0, WR_n0}, 32'd7);
        check_eq("rstx_oe_rsp_rdy", {29'd0, D_oe0, if0.rsp_valid, if0.req_ready}, 32'd1);
        step();
        check_eq("rstx_no_late_rsp", {31'd0, if0.rsp_valid}, 32'd0);
        step();

        // Idle grant pass-through
        for (int k = 0; k < 3; k++) begin
            enin0 = (k == 1);
            #1;
            check_eq($sformatf("enout_pass%0d", k), {31'd0, enout0}, {31'd0, (k == 1)});
        end
        enin0 = 1'b1;
        step();

        // Back-to-back requests, no wait, no arbitration
        if0.req_valid = 1'b1;
        if0.req_write = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (if0.req_ready && if0.req_valid) acc.push_back(c);
            step();
        end
        if0.req_valid = 1'b0;
        check_eq("b2b_accepts", acc.size(), 32'd4);
        if (acc.size() >= 3) begin
            check_eq("b2b_gap1", acc[1] - acc[0], 32'd4);
            check_eq("b2b_gap2", acc[2] - acc[1], 32'd4);
        end
        repeat (4) step();

`ifdef SCMP_BUS_ARB_EN
        // Arbitration: busy for four cycles from accept
        busy0 = 1'b1;
        if0.req_valid = 1'b1;
        if0.req_addr  = 16'h0200;
        #1;
        check_eq("arb_t0_enout", {31'd0, enout0}, 32'd0);
        step();
        if0.req_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check_eq($sformatf("arb_wait%0d", k), {29'd0, breq0, ADS_n0, enout0}, 32'h6);
            step();
        end
        busy0 = 1'b0;
        check_eq("arb_t4_ads_n", {31'd0, ADS_n0}, 32'd1);
        step();
        check_eq("arb_t5_ads", {30'd0, ADS_n0, enout0}, 32'd0);
        step();
        check_eq("arb_t6_xfer", {30'd0, RD_n0, enout0}, 32'd0);
        step();
        check_eq("arb_t7_tail", {29'd0, if0.rsp_valid, breq0, enout0}, 32'h6);
        step();
        check_eq("arb_t8_idle", {30'd0, breq0, enout0}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
